// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans the sprite attribute RAM for one scanline and
// writes up to MAX_PER_LINE hits, in index order, into a per-line list.
module sprite_line_scheduler #(
    parameter int NUM_SPRITE   = 32,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_H     = 16,
    localparam int RW = $clog2(NUM_SPRITE),
    localparam int AW = $clog2(MAX_PER_LINE),
    localparam int CW = $clog2(MAX_PER_LINE) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [9:0]    line,
    output logic [RW-1:0] ra,
    input  logic [31:0]   q,
    output logic          lw_en,
    output logic [AW-1:0] lw_addr,
    output logic [31:0]   lw_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      st;
    logic [9:0]  tgt;
    logic        eval, hit, full, wr;
    logic        en_b;
    logic [9:0]  x, y;
    logic [7:0]  tile;
    logic [3:0]  row;
    logic        unused_rsvd;

    assign en_b        = q[31];
    assign x           = q[30:21];
    assign y           = q[20:11];
    assign tile        = q[7:0];
    assign unused_rsvd = ^q[10:8];

    // q holds the entry issued last cycle: every SCAN cycle but the first, plus DRAIN
    assign eval = (st == DRAIN) || (st == SCAN && ra != '0);
    assign hit  = en_b && ({1'b0, tgt} >= {1'b0, y}) &&
                  ({1'b0, tgt} < ({1'b0, y} + 11'(SPRITE_H)));
    assign row  = tgt[3:0] - y[3:0];
    assign full = count == CW'(MAX_PER_LINE);
    assign wr   = eval && hit && !full;

    assign lw_en   = wr;
    assign lw_addr = wr ? count[AW-1:0] : '0;
    assign lw_data = wr ? {x, row, 10'b0, tile} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= IDLE;
            ra       <= '0;
            tgt      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (eval && hit) begin
                if (full) overflow <= 1'b1;
                else      count    <= count + 1'b1;
            end
            case (st)
                IDLE: if (start) begin
                    tgt      <= line;
                    count    <= '0;
                    overflow <= 1'b0;
                    ra       <= '0;
                    busy     <= 1'b1;
                    st       <= SCAN;
                end
                SCAN: if (ra == RW'(NUM_SPRITE - 1)) begin
                    ra <= '0;
                    st <= DRAIN;
                end else begin
                    ra <= ra + 1'b1;
                end
                DRAIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= DONE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed table vectors plus hand-written sequences
// for latency, overflow, ignored start and mid-scan reset.
module tb_sprite_line_scheduler;
    logic        clk = 0, reset_n = 0, start = 0;
    logic [9:0]  line = 0;
    logic [4:0]  ra;
    logic [31:0] q = 0;
    logic        lw_en;
    logic [2:0]  lw_addr;
    logic [31:0] lw_data;
    logic        busy, done, overflow;
    logic [3:0]  count;
    logic [31:0] mem [32];

    int checks = 0, errors = 0;
    int nbusy, busy_bad, done_cyc, ndone, nwr, ra_bad, stray_wr;
    logic [2:0]  wa [16];
    logic [31:0] wd [16];

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [9:0]  ln;
        int          hits;
        logic [31:0] d;
    } vec_t;
    vec_t tv [8];

    always #5 clk = ~clk;
    always @(posedge clk) q <= mem[ra];

    sprite_line_scheduler dut (
        .clk(clk), .reset_n(reset_n), .start(start), .line(line), .ra(ra), .q(q),
        .lw_en(lw_en), .lw_addr(lw_addr), .lw_data(lw_data), .busy(busy),
        .done(done), .count(count), .overflow(overflow)
    );

    function automatic logic [31:0] attr(logic en, logic [9:0] x, logic [9:0] y, logic [7:0] t);
        return {en, x, y, 3'b000, t};
    endfunction

    function automatic logic [31:0] mk(logic [9:0] x, logic [3:0] r, logic [7:0] t);
        return {x, r, 10'b0, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    // Called at a falling edge; start is sampled on the next rising edge (cycle 1 follows it).
    task automatic run(input logic [9:0] ln, input int pulse_at);
        nbusy = 0; busy_bad = 0; done_cyc = 0; ndone = 0; nwr = 0; ra_bad = 0; stray_wr = 0;
        line  = ln;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            if (c == pulse_at) line = 10'd95;
            if (busy) nbusy++;
            if (busy !== (c <= 33)) busy_bad++;
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (ra !== ((c <= 32) ? 5'(c - 1) : 5'd0)) ra_bad++;
            if (lw_en) begin
                if (!busy) stray_wr++;
                if (nwr < 16) begin
                    wa[nwr] = lw_addr;
                    wd[nwr] = lw_data;
                end
                nwr++;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ra"}, 32'(ra), 0);
        chk({tag, "_lw_en"}, 32'(lw_en), 0);
        chk({tag, "_lw_addr"}, 32'(lw_addr), 0);
        chk({tag, "_lw_data"}, lw_data, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        tv[0] = '{0,  attr(1, 10, 85, 8'h11),    10'd100,  1, mk(10, 15, 8'h11)};
        tv[1] = '{5,  attr(1, 10, 84, 8'h11),    10'd100,  0, 32'h0};
        tv[2] = '{9,  attr(1, 300, 1020, 8'h22), 10'd3,    0, 32'h0};
        tv[3] = '{31, attr(1, 1023, 100, 8'hff), 10'd100,  1, mk(1023, 0, 8'hff)};
        tv[4] = '{12, attr(0, 5, 100, 8'h01),    10'd100,  0, 32'h0};
        tv[5] = '{0,  attr(1, 7, 1008, 8'h33),   10'd1023, 1, mk(7, 15, 8'h33)};
        tv[6] = '{16, attr(1, 512, 1020, 8'h44), 10'd1023, 1, mk(512, 3, 8'h44)};
        tv[7] = '{2,  attr(1, 1, 0, 8'h55) | 32'h700, 10'd0, 1, mk(1, 0, 8'h55)};

        clear_mem();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset_n = 1'b1;

        run(10'd100, 0);
        chk("empty_nbusy", nbusy, 33);
        chk("empty_busy_shape", busy_bad, 0);
        chk("empty_done_cyc", done_cyc, 34);
        chk("empty_ndone", ndone, 1);
        chk("empty_nwr", nwr, 0);
        chk("empty_count", 32'(count), 0);
        chk("empty_ra_seq", ra_bad, 0);

        for (int i = 0; i < 8; i++) begin
            clear_mem();
            mem[tv[i].idx] = tv[i].a;
            run(tv[i].ln, 0);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].hits));
            chk($sformatf("v%0d_nwr", i), nwr, tv[i].hits);
            chk($sformatf("v%0d_done_cyc", i), done_cyc, 34);
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 0);
            if (tv[i].hits == 1) begin
                chk($sformatf("v%0d_addr", i), 32'(wa[0]), 0);
                chk($sformatf("v%0d_data", i), wd[0], tv[i].d);
            end
        end

        clear_mem();
        mem[3] = attr(1, 40, 90, 8'h09);
        mem[7] = attr(1, 200, 100, 8'h05);
        run(10'd100, 0);
        chk("two_nwr", nwr, 2);
        chk("two_a0", 32'(wa[0]), 0);
        chk("two_d0", wd[0], mk(40, 10, 8'h09));
        chk("two_a1", 32'(wa[1]), 1);
        chk("two_d1", wd[1], mk(200, 0, 8'h05));
        chk("two_count", 32'(count), 2);
        chk("two_stray", stray_wr, 0);

        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = attr(1, 10'(i * 10), 50, 8'(i));
        run(10'd55, 0);
        chk("ovf_nwr", nwr, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_a%0d", i), 32'(wa[i]), 32'(i));
            chk($sformatf("ovf_d%0d", i), wd[i], mk(10'(i * 10), 5, 8'(i)));
        end
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_done_cyc", done_cyc, 34);
        repeat (5) @(negedge clk);
        chk("ovf_count_hold", 32'(count), 8);
        chk("ovf_flag_hold", 32'(overflow), 1);

        clear_mem();
        mem[3] = attr(1, 40, 90, 8'h09);
        mem[7] = attr(1, 200, 100, 8'h05);
        run(10'd100, 5);
        chk("restart_ndone", ndone, 1);
        chk("restart_done_cyc", done_cyc, 34);
        chk("restart_nwr", nwr, 2);
        chk("restart_d0", wd[0], mk(40, 10, 8'h09));
        chk("restart_count", 32'(count), 2);
        chk("restart_ovf_cleared", 32'(overflow), 0);

        mem[20] = attr(1, 77, 95, 8'h0a);
        line  = 10'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        nwr = 0;
        repeat (2) begin
            @(negedge clk);
            if (lw_en || busy) nwr++;
        end
        chk("midrst_quiet", nwr, 0);
        reset_n = 1'b1;
        run(10'd100, 0);
        chk("after_rst_done_cyc", done_cyc, 34);
        chk("after_rst_nwr", nwr, 3);
        chk("after_rst_d2", wd[2], mk(77, 5, 8'h0a));
        chk("after_rst_count", 32'(count), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
